uart_cmd_framer: RTL and testbench

Parametrised byte-to-command framer and response serializer between a byte-level UART and the command processor. It assembles `CMD_BYTES` received bytes (MSB first) into one command word, queues complete commands in a `FIFO_DEPTH`-entry buffer, and discards partial frames after an inter-byte timeout. It also sends a `RESP_BYTES`-wide response as back-to-back UART bytes from a single request.

---
 rtl/uart_cmd_framer.sv | 213 +++++++++++++++++++++
 tb/tb_uart_cmd_framer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_framer.sv
// uart_cmd_framer
// Assembles CMD_BYTES received UART bytes (first byte = MSB) into command
// words and queues them in a small FIFO. A partial frame that sees no new
// byte for TIMEOUT_CYC clocks is discarded. On request, a RESP_BYTES-wide
// response word is sent out as back-to-back UART bytes, MSB first.
module uart_cmd_framer #(
    parameter int CMD_BYTES   = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 50000,
    parameter int RESP_BYTES  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx_rdy,
    input  logic [7:0]                rx_data,
    output logic                      clr_rx_rdy,
    output logic [8*CMD_BYTES-1:0]    cmd,
    output logic                      cmd_rdy,
    input  logic                      clr_cmd_rdy,
    output logic                      cmd_ovfl,
    output logic                      frame_err,
    input  logic                      clr_err,
    input  logic                      send_resp,
    input  logic [8*RESP_BYTES-1:0]   resp,
    output logic                      resp_busy,
    output logic                      resp_done,
    output logic                      trmt,
    output logic [7:0]                tx_data,
    input  logic                      tx_done
);

    localparam int CMD_W  = 8 * CMD_BYTES;
    localparam int RESP_W = 8 * RESP_BYTES;
    localparam int IDX_W  = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int RC_W   = $clog2(RESP_BYTES + 1);

    localparam logic [IDX_W-1:0] IDX_ZERO = '0;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CMD_BYTES - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);
    localparam logic [AW:0]      PTR_ONE  = (AW + 1)'(1);
    localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);
    localparam logic [RC_W-1:0]  RC_FULL  = RC_W'(RESP_BYTES);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_SEND,
        TX_WAIT
    } tx_state_t;

    // Receive-side assembly state
    logic [IDX_W-1:0] byte_idx;
    logic [TO_W-1:0]  to_cnt;
    logic [CMD_W-1:0] asm_word;
    logic             timeout_hit;
    logic [IDX_W-1:0] cur_idx;
    logic             push;
    logic [CMD_W-1:0] push_word;

    // Command FIFO
    logic [CMD_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             push_drop;

    // Response serializer
    tx_state_t         tx_state;
    logic [RESP_W-1:0] tx_shift;
    logic [RC_W-1:0]   resp_cnt;

    // Every presented byte is consumed in the same cycle.
    assign clr_rx_rdy = rx_rdy;

    // Timeout takes precedence over a byte arriving in the same cycle, so that
    // byte restarts a new frame at index 0; the final byte is bypassed straight
    // into the pushed word.
    always_comb begin
        timeout_hit = (byte_idx != IDX_ZERO) && (to_cnt == TO_LIMIT);
        cur_idx     = timeout_hit ? IDX_ZERO : byte_idx;
        push        = rx_rdy && (cur_idx == LAST_IDX);
        push_word   = asm_word;
        push_word[7:0] = rx_data;
    end

    // Byte assembly, inter-byte timeout counter and frame error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx  <= IDX_ZERO;
            to_cnt    <= '0;
            asm_word  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= timeout_hit;
            if (rx_rdy) begin
                for (int k = 0; k < CMD_BYTES; k++) begin
                    if (cur_idx == IDX_W'(k)) begin
                        asm_word[8*(CMD_BYTES-k)-1 -: 8] <= rx_data;
                    end
                end
                byte_idx <= (cur_idx == LAST_IDX) ? IDX_ZERO : (cur_idx + IDX_ONE);
                to_cnt   <= '0;
            end else if (timeout_hit) begin
                byte_idx <= IDX_ZERO;
                to_cnt   <= '0;
            end else if (byte_idx != IDX_ZERO) begin
                to_cnt <= to_cnt + TO_ONE;
            end
        end
    end

    // FIFO status; a pop frees a slot in the same cycle so a push into a full
    // FIFO alongside a pop is not an overflow.
    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop        = clr_cmd_rdy && !fifo_empty;
        push_ok    = push && (!fifo_full || pop);
        push_drop  = push && fifo_full && !pop;
    end

    assign cmd     = mem[rd_ptr[AW-1:0]];
    assign cmd_rdy = !fifo_empty;

    // FIFO storage, pointers and the sticky overflow flag (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cmd_ovfl <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_word;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_drop) begin
                cmd_ovfl <= 1'b1;
            end else if (clr_err) begin
                cmd_ovfl <= 1'b0;
            end
        end
    end

    // Response FSM: the first byte strobes one cycle after the request, later
    // bytes pass through LOAD so they strobe two cycles after tx_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            tx_shift  <= '0;
            resp_cnt  <= '0;
            trmt      <= 1'b0;
            tx_data   <= 8'h00;
            resp_busy <= 1'b0;
            resp_done <= 1'b0;
        end else begin
            trmt      <= 1'b0;
            resp_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (send_resp) begin
                        tx_shift  <= resp;
                        resp_cnt  <= RC_FULL;
                        tx_data   <= resp[RESP_W-1 -: 8];
                        trmt      <= 1'b1;
                        resp_busy <= 1'b1;
                        tx_state  <= TX_SEND;
                    end
                end
                TX_LOAD: begin
                    tx_data  <= tx_shift[RESP_W-1 -: 8];
                    trmt     <= 1'b1;
                    tx_state <= TX_SEND;
                end
                TX_SEND: begin
                    tx_state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        if (resp_cnt == RC_ONE) begin
                            resp_cnt  <= '0;
                            resp_done <= 1'b1;
                            resp_busy <= 1'b0;
                            tx_state  <= TX_IDLE;
                        end else begin
                            resp_cnt <= resp_cnt - RC_ONE;
                            tx_shift <= tx_shift << 8;
                            tx_state <= TX_LOAD;
                        end
                    end
                end
                default: begin
                    tx_state  <= TX_IDLE;
                    resp_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// Testbench for uart_cmd_framer: directed vectors with hand-computed results.
// Inputs change 1 ns after the rising edge; outputs are sampled there too,
// so registered results of cycle N are observed in cycle N+1.
module tb_uart_cmd_framer;

    localparam int CMD_BYTES   = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 20;
    localparam int RESP_BYTES  = 3;

    logic        clk;
    logic        rst_n;
    logic        rx_rdy;
    logic [7:0]  rx_data;
    logic        clr_rx_rdy;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_ovfl;
    logic        frame_err;
    logic        clr_err;
    logic        send_resp;
    logic [23:0] resp;
    logic        resp_busy;
    logic        resp_done;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;

    int checks;
    int failures;
    int trmt_cnt;
    int done_cnt;
    int ferr_cnt;

    typedef struct {
        logic        rdy;
        logic [7:0]  data;
        logic        pop;
        logic        clr;
        logic        exp_rdy;
        logic [15:0] exp_cmd;
        logic        exp_ovfl;
    } fifo_vec_t;

    fifo_vec_t vecs [16];

    uart_cmd_framer #(
        .CMD_BYTES  (CMD_BYTES),
        .FIFO_DEPTH (FIFO_DEPTH),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .RESP_BYTES (RESP_BYTES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd_ovfl   (cmd_ovfl),
        .frame_err  (frame_err),
        .clr_err    (clr_err),
        .send_resp  (send_resp),
        .resp       (resp),
        .resp_busy  (resp_busy),
        .resp_done  (resp_done),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse counters sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (trmt)      trmt_cnt++;
        if (resp_done) done_cnt++;
        if (frame_err) ferr_cnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drives one clock cycle of inputs, then returns 1 ns into the next cycle
    // with all strobes released.
    task automatic applyStimulus(input logic rdy, input logic [7:0] data,
                                 input logic pop, input logic clr,
                                 input logic snd, input logic done);
        rx_rdy      = rdy;
        rx_data     = data;
        clr_cmd_rdy = pop;
        clr_err     = clr;
        send_resp   = snd;
        tx_done     = done;
        #1;
        checkOutput("clr_rx_rdy", {31'd0, clr_rx_rdy}, {31'd0, rdy});
        @(posedge clk);
        #1;
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
        clr_err     = 1'b0;
        send_resp   = 1'b0;
        tx_done     = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_cmd();
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_tx [3];
        int ferr_base;
        int trmt_base;
        int done_base;

        checks   = 0;
        failures = 0;
        trmt_cnt = 0;
        done_cnt = 0;
        ferr_cnt = 0;

        // FIFO table: five pushes (last one dropped), pops, empty pop, clear.
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0};
        vecs[2]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0};
        vecs[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0};
        vecs[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0};
        vecs[5]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0};
        vecs[6]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0};
        vecs[7]  = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0};
        vecs[8]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b0};
        vecs[9]  = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 16'h0101, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0202, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0303, 1'b1};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0404, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0101, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0101, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0101, 1'b0};

        exp_tx[0] = 8'hDE;
        exp_tx[1] = 8'hAD;
        exp_tx[2] = 8'hBE;

        rst_n       = 1'b0;
        rx_rdy      = 1'b0;
        rx_data     = 8'h00;
        clr_cmd_rdy = 1'b0;
        clr_err     = 1'b0;
        send_resp   = 1'b0;
        resp        = 24'h000000;
        tx_done     = 1'b0;

        // Reset state
        #23;
        checkOutput("reset.cmd", {16'd0, cmd}, 32'h0);
        checkOutput("reset.cmd_rdy", {31'd0, cmd_rdy}, 32'h0);
        checkOutput("reset.cmd_ovfl", {31'd0, cmd_ovfl}, 32'h0);
        checkOutput("reset.frame_err", {31'd0, frame_err}, 32'h0);
        checkOutput("reset.trmt", {31'd0, trmt}, 32'h0);
        checkOutput("reset.tx_data", {24'd0, tx_data}, 32'h0);
        checkOutput("reset.resp_busy", {31'd0, resp_busy}, 32'h0);
        checkOutput("reset.resp_done", {31'd0, resp_done}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // Two-byte frame with the second byte just before the timeout limit
        $display("[TB] frame assembly");
        send_byte(8'hA5);
        checkOutput("asm.rdy_after_first", {31'd0, cmd_rdy}, 32'h0);
        idle_cycles(19);
        send_byte(8'h3C);
        checkOutput("asm.cmd_rdy", {31'd0, cmd_rdy}, 32'h1);
        checkOutput("asm.cmd", {16'd0, cmd}, 32'hA53C);
        checkOutput("asm.no_frame_err", ferr_cnt, 0);
        pop_cmd();
        checkOutput("asm.pop_rdy", {31'd0, cmd_rdy}, 32'h0);

        // Table-driven FIFO fill/overflow/drain
        $display("[TB] fifo table");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].rdy, vecs[i].data, vecs[i].pop, vecs[i].clr, 1'b0, 1'b0);
            checkOutput($sformatf("fifo[%0d].cmd_rdy", i), {31'd0, cmd_rdy}, {31'd0, vecs[i].exp_rdy});
            checkOutput($sformatf("fifo[%0d].cmd", i), {16'd0, cmd}, {16'd0, vecs[i].exp_cmd});
            checkOutput($sformatf("fifo[%0d].cmd_ovfl", i), {31'd0, cmd_ovfl}, {31'd0, vecs[i].exp_ovfl});
        end

        // Full FIFO: push with simultaneous pop, then overflow with clr_err
        $display("[TB] full fifo corner cases");
        send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h44);
        checkOutput("full.head", {16'd0, cmd}, 32'h1111);
        send_byte(8'h06);
        applyStimulus(1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("full.pushpop_ovfl", {31'd0, cmd_ovfl}, 32'h0);
        checkOutput("full.pushpop_head", {16'd0, cmd}, 32'h2222);
        send_byte(8'h07);
        applyStimulus(1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("full.set_beats_clr", {31'd0, cmd_ovfl}, 32'h1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("full.clr_err", {31'd0, cmd_ovfl}, 32'h0);
        pop_cmd();
        checkOutput("full.pop1", {16'd0, cmd}, 32'h3333);
        pop_cmd();
        checkOutput("full.pop2", {16'd0, cmd}, 32'h4444);
        pop_cmd();
        checkOutput("full.last_entry", {16'd0, cmd}, 32'h0606);
        checkOutput("full.last_rdy", {31'd0, cmd_rdy}, 32'h1);
        pop_cmd();
        checkOutput("full.drained", {31'd0, cmd_rdy}, 32'h0);

        // Partial frame timeout
        $display("[TB] timeout");
        ferr_base = ferr_cnt;
        send_byte(8'h11);
        idle_cycles(20);
        checkOutput("to.before_limit", {31'd0, frame_err}, 32'h0);
        idle_cycles(1);
        checkOutput("to.pulse", {31'd0, frame_err}, 32'h1);
        idle_cycles(1);
        checkOutput("to.pulse_end", {31'd0, frame_err}, 32'h0);
        idle_cycles(3);
        send_byte(8'h22);
        checkOutput("to.no_stale_cmd", {31'd0, cmd_rdy}, 32'h0);
        send_byte(8'h33);
        checkOutput("to.cmd", {16'd0, cmd}, 32'h2233);
        checkOutput("to.cmd_rdy", {31'd0, cmd_rdy}, 32'h1);
        checkOutput("to.one_pulse", ferr_cnt - ferr_base, 1);
        pop_cmd();

        // Byte arriving in the timeout cycle starts a new frame
        $display("[TB] timeout coincident with byte");
        send_byte(8'h77);
        idle_cycles(20);
        send_byte(8'h88);
        checkOutput("toc.pulse", {31'd0, frame_err}, 32'h1);
        checkOutput("toc.no_push", {31'd0, cmd_rdy}, 32'h0);
        send_byte(8'h99);
        checkOutput("toc.cmd", {16'd0, cmd}, 32'h8899);
        checkOutput("toc.cmd_rdy", {31'd0, cmd_rdy}, 32'h1);
        pop_cmd();

        // Three-byte response
        $display("[TB] response serializer");
        trmt_base = trmt_cnt;
        done_base = done_cnt;
        resp = 24'hDEADBE;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        resp = 24'h123456;
        checkOutput("tx.first_trmt", {31'd0, trmt}, 32'h1);
        checkOutput("tx.first_byte", {24'd0, tx_data}, {24'd0, exp_tx[0]});
        checkOutput("tx.busy", {31'd0, resp_busy}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, (i == 0), 1'b0);
            checkOutput($sformatf("tx[%0d].strobe_1cyc", i), {31'd0, trmt}, 32'h0);
            idle_cycles(8);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("tx[%0d].data_hold", i), {24'd0, tx_data}, {24'd0, exp_tx[i]});
            if (i == 2) begin
                checkOutput("tx.resp_done", {31'd0, resp_done}, 32'h1);
                checkOutput("tx.busy_end", {31'd0, resp_busy}, 32'h0);
            end else begin
                checkOutput($sformatf("tx[%0d].gap", i), {31'd0, trmt}, 32'h0);
                checkOutput($sformatf("tx[%0d].busy", i), {31'd0, resp_busy}, 32'h1);
                idle_cycles(1);
                checkOutput($sformatf("tx[%0d].next_trmt", i), {31'd0, trmt}, 32'h1);
                checkOutput($sformatf("tx[%0d].next_byte", i), {24'd0, tx_data}, {24'd0, exp_tx[i+1]});
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("tx.done_idle_ignored", {31'd0, resp_done}, 32'h0);
        idle_cycles(5);
        checkOutput("tx.trmt_count", trmt_cnt - trmt_base, 3);
        checkOutput("tx.done_count", done_cnt - done_base, 1);
        checkOutput("tx.idle_after", {31'd0, resp_busy}, 32'h0);

        // Reset mid-frame and mid-response
        $display("[TB] reset abort");
        send_byte(8'h55);
        send_byte(8'h66);
        checkOutput("rst.pre_cmd", {16'd0, cmd}, 32'h5566);
        resp = 24'hC0FFEE;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle_cycles(9);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        idle_cycles(1);
        checkOutput("rst.second_byte", {24'd0, tx_data}, 32'hFF);
        send_byte(8'h12);
        rst_n = 1'b0;
        #1;
        checkOutput("rst.cmd", {16'd0, cmd}, 32'h0);
        checkOutput("rst.cmd_rdy", {31'd0, cmd_rdy}, 32'h0);
        checkOutput("rst.trmt", {31'd0, trmt}, 32'h0);
        checkOutput("rst.tx_data", {24'd0, tx_data}, 32'h0);
        checkOutput("rst.resp_busy", {31'd0, resp_busy}, 32'h0);
        checkOutput("rst.resp_done", {31'd0, resp_done}, 32'h0);
        checkOutput("rst.frame_err", {31'd0, frame_err}, 32'h0);
        checkOutput("rst.cmd_ovfl", {31'd0, cmd_ovfl}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst.trmt_held", {31'd0, trmt}, 32'h0);
        rst_n = 1'b1;
        idle_cycles(2);
        checkOutput("rst.busy_after", {31'd0, resp_busy}, 32'h0);
        send_byte(8'h12);
        checkOutput("rst.fresh_partial", {31'd0, cmd_rdy}, 32'h0);
        send_byte(8'h34);
        checkOutput("rst.fresh_cmd", {16'd0, cmd}, 32'h1234);
        checkOutput("rst.fresh_rdy", {31'd0, cmd_rdy}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
